// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU: latency 1 for logic/arith/shift ops, WIDTH+... cycles for iterative MUL (out_valid after edge k+WIDTH).
// Backpressure: result held while out_valid && !out_ready; in_ready low during MUL and while a result is stalled.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_n_q, flag_n_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_v_q, flag_v_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH:0]       add_full, sub_full, shl_full, shr_full;
    logic [SW-1:0]        shamt;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v;
    logic [WIDTH:0]       pp_sum;
    logic [2*WIDTH-1:0]   acc_step;

    always_comb begin
        add_full = {1'b0, OP1} + {1'b0, OP2};
        sub_full = {1'b0, OP1} - {1'b0, OP2};
        shamt    = OP2[SW-1:0];
        // The extra bit on each side catches the last bit shifted out (0 when shamt is 0).
        shl_full = {1'b0, OP1} << shamt;
        shr_full = {OP1, 1'b0} >> shamt;
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (OPCODE)
            OP_ADD: begin
                alu_r = add_full[WIDTH-1:0];
                alu_c = add_full[WIDTH];
                alu_v = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (add_full[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_full[WIDTH-1:0];
                alu_c = sub_full[WIDTH];
                alu_v = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (sub_full[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_AND: alu_r = OP1 & OP2;
            OP_OR:  alu_r = OP1 | OP2;
            OP_XOR: alu_r = OP1 ^ OP2;
            OP_SHL: begin
                alu_r = shl_full[WIDTH-1:0];
                alu_c = shl_full[WIDTH];
            end
            OP_SHR: begin
                alu_r = shr_full[WIDTH:1];
                alu_c = shr_full[0];
            end
            default: begin
                alu_r = '0;
            end
        endcase
        // Overflow direction always follows OP1's sign for both ADD and SUB.
        if (SAT_EN && alu_v) begin
            alu_r = OP1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Right-shifting shift-add: acc holds {partial high, remaining multiplier bits}.
    always_comb begin
        pp_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {pp_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        in_ready    = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (OPCODE == OP_MUL) begin
                        mcand_d = OP1;
                        acc_d   = {{WIDTH{1'b0}}, OP2};
                        cnt_d   = '0;
                        state_d = MUL_BUSY;
                    end else begin
                        result_d    = alu_r;
                        result_hi_d = '0;
                        flag_z_d    = (alu_r == '0);
                        flag_n_d    = alu_r[WIDTH-1];
                        flag_c_d    = alu_c;
                        flag_v_d    = alu_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(WIDTH-1)) begin
                    result_d    = acc_step[WIDTH-1:0];
                    result_hi_d = acc_step[2*WIDTH-1:WIDTH];
                    flag_z_d    = (acc_step[WIDTH-1:0] == '0);
                    flag_n_d    = acc_step[WIDTH-1];
                    flag_c_d    = |acc_step[2*WIDTH-1:WIDTH];
                    flag_v_d    = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: one wrapping and one saturating instance, scoreboard-checked outputs.
module tb_alu_pipe;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SHL = 3'd5;
    localparam logic [2:0] SHR = 3'd6;
    localparam logic [2:0] MUL = 3'd7;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] rh;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] OPCODE;
    logic [7:0] OP1, OP2;
    logic       out_ready;
    logic       in_valid_w, in_ready_w, out_valid_w;
    logic       in_valid_s, in_ready_s, out_valid_s;
    logic [7:0] result_w, result_hi_w, result_s, result_hi_s;
    logic       fz_w, fn_w, fc_w, fv_w, fz_s, fn_s, fc_s, fv_s;
    exp_t       obs_w, obs_s, ew, es;
    exp_t       q_w[$];
    exp_t       q_s[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .SAT_EN(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .result_hi(result_hi_w),
        .flag_z(fz_w), .flag_n(fn_w), .flag_c(fc_w), .flag_v(fv_w)
    );

    alu_pipe #(.WIDTH(8), .SAT_EN(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .result_hi(result_hi_s),
        .flag_z(fz_s), .flag_n(fn_s), .flag_c(fc_s), .flag_v(fv_s)
    );

    assign obs_w = {result_w, result_hi_w, fz_w, fn_w, fc_w, fv_w};
    assign obs_s = {result_s, result_hi_s, fz_s, fn_s, fc_s, fv_s};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic [7:0] rh, input logic c, input logic v);
        return {r, rh, (r == 8'h00), r[7], c, v};
    endfunction

    // Reference computed with integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input bit sat, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, t, s, amt;
        logic [7:0] r;
        logic [7:0] rh;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        amt = ub % 8;
        r = 8'h00; rh = 8'h00; c = 1'b0; v = 1'b0; t = 0; s = 0;
        case (op)
            ADD: begin t = ua + ub; r = t[7:0]; c = (t > 255); s = sa + sb; v = (s > 127) || (s < -128); end
            SUB: begin t = ua - ub; r = t[7:0]; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
            AND: r = a & b;
            OR:  r = a | b;
            XOR: r = a ^ b;
            SHL: begin t = ua << amt; r = t[7:0]; c = (amt != 0) && t[8]; end
            SHR: begin
                t = ua >> amt; r = t[7:0];
                if (amt != 0) begin t = ua >> (amt - 1); c = t[0]; end
            end
            default: begin t = ua * ub; r = t[7:0]; rh = t[15:8]; c = (rh != 8'h00); end
        endcase
        if (sat && v) r = (sa < 0) ? 8'h80 : 8'h7F;
        return {r, rh, (r == 8'h00), r[7], c, v};
    endfunction

    // Offer one operation; expectation is queued only when the handshake completes.
    task automatic send(input bit sat, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input bit push);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        OPCODE = op; OP1 = a; OP2 = b;
        if (sat) in_valid_s = 1'b1; else in_valid_w = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sat ? in_ready_s : in_ready_w) begin
                if (push) begin
                    if (sat) q_s.push_back(e); else q_w.push_back(e);
                end
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'(sat ? in_ready_s : in_ready_w), 32'd1);
        in_valid_w = 1'b0;
        in_valid_s = 1'b0;
    endtask

    // Back-to-back non-MUL stream with in_valid held high: in_ready must stay up every cycle.
    task automatic burst(input bit sat, input int n);
        logic [2:0] op;
        logic [7:0] a, b;
        logic rdy;
        for (int k = 0; k < n; k++) begin
            op = 3'($urandom_range(0, 6));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            OPCODE = op; OP1 = a; OP2 = b;
            if (sat) in_valid_s = 1'b1; else in_valid_w = 1'b1;
            @(negedge clk);
            rdy = sat ? in_ready_s : in_ready_w;
            chk("b2b_ready", 32'(rdy), 32'd1);
            if (rdy) begin
                if (sat) q_s.push_back(model(sat, op, a, b)); else q_w.push_back(model(sat, op, a, b));
            end
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0;
        in_valid_s = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_w && out_ready) begin
            if (q_w.size() == 0) chk("spurious_w", 32'(out_valid_w), 32'd0);
            else begin
                ew = q_w.pop_front();
                chk("result_w", 32'(obs_w), 32'(ew));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_s && out_ready) begin
            if (q_s.size() == 0) chk("spurious_s", 32'(out_valid_s), 32'd0);
            else begin
                es = q_s.pop_front();
                chk("result_s", 32'(obs_s), 32'(es));
            end
        end
    end

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        rst = 1'b0; in_valid_w = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
        OPCODE = 3'd0; OP1 = 8'h00; OP2 = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_w", 32'({out_valid_w, obs_w}), 32'd0);
        chk("reset_s", 32'({out_valid_s, obs_s}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready_w), 32'd1);

        send(0, ADD, 8'h7F, 8'h01, mk(8'h80, 8'h00, 1'b0, 1'b1), 1);
        @(negedge clk);
        chk("add_latency", 32'(out_valid_w), 32'd1);
        send(1, ADD, 8'h7F, 8'h01, mk(8'h7F, 8'h00, 1'b0, 1'b1), 1);
        send(1, SUB, 8'h80, 8'h01, mk(8'h80, 8'h00, 1'b0, 1'b1), 1);
        send(0, SUB, 8'h80, 8'h01, mk(8'h7F, 8'h00, 1'b0, 1'b1), 1);
        send(0, SUB, 8'h00, 8'h01, mk(8'hFF, 8'h00, 1'b1, 1'b0), 1);
        send(0, SHL, 8'h81, 8'h01, mk(8'h02, 8'h00, 1'b1, 1'b0), 1);
        send(0, SHR, 8'h01, 8'h00, mk(8'h01, 8'h00, 1'b0, 1'b0), 1);
        send(0, SHR, 8'h81, 8'h0B, mk(8'h10, 8'h00, 1'b0, 1'b0), 1);
        send(0, AND, 8'hF0, 8'h3C, mk(8'h30, 8'h00, 1'b0, 1'b0), 1);
        send(0, XOR, 8'h55, 8'h55, mk(8'h00, 8'h00, 1'b0, 1'b0), 1);
        send(0, OR,  8'hA0, 8'h05, mk(8'hA5, 8'h00, 1'b0, 1'b0), 1);

        send(0, MUL, 8'h0F, 8'h11, mk(8'hFF, 8'h00, 1'b0, 1'b0), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mul_busy_ready", 32'(in_ready_w), 32'd0);
            chk("mul_busy_valid", 32'(out_valid_w), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("mul_done_valid", 32'(out_valid_w), 32'd1);
        send(0, MUL, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 1'b1, 1'b0), 1);
        repeat (10) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(0, ADD, 8'h10, 8'h20, mk(8'h30, 8'h00, 1'b0, 1'b0), 1);
        OPCODE = ADD; OP1 = 8'h01; OP2 = 8'h02; in_valid_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(in_ready_w), 32'd0);
            chk("stall_hold", 32'({out_valid_w, result_w}), 32'h130);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(in_ready_w), 32'd1);
        q_w.push_back(mk(8'h03, 8'h00, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        @(negedge clk);
        chk("consume_accept", 32'({out_valid_w, result_w}), 32'h103);
        @(posedge clk);
        @(negedge clk);
        chk("consume_only", 32'({out_valid_w, result_w}), 32'h003);

        send(0, MUL, 8'h0F, 8'h11, mk(8'h00, 8'h00, 1'b0, 1'b0), 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_mul", 32'({out_valid_w, obs_w}), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        send(0, ADD, 8'h01, 8'h01, mk(8'h02, 8'h00, 1'b0, 1'b0), 1);
        @(negedge clk);
        chk("post_reset_add", 32'(out_valid_w), 32'd1);

        @(posedge clk); #1;
        burst(0, 12);
        burst(1, 10);
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            send(0, rop, ra, rb, model(0, rop, ra, rb), 1);
        end

        for (int i = 0; i < 100 && (q_w.size() != 0 || q_s.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("drain_w", 32'(q_w.size()), 32'd0);
        chk("drain_s", 32'(q_s.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
